dsram_responder: RTL and testbench
==================================

# dsram_responder

Memory-side responder for the CPU's data SRAM port: it accepts the `en`/`wen`/`addr`/`wdata` requests issued by the MEM stage and returns `rdata` one cycle later, as the synchronous data RAM does. It contains a byte-writable word RAM and a small MMIO window: a 16-bit LED register, a free-running 32-bit timer and a read-only switch port. It sits in the SoC top between the CPU core's data port and the board I/O.

## Interface
- `ADDR_W`, 10, word-index width of the RAM (DEPTH = 2^ADDR_W words).
- `MMIO_HI`, 16'hBFAF, value of `addr[31:16]` that selects the MMIO window.
- `clk`  in  1  clock; all logic on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `en`  in  1  request valid this cycle.
- `wen`  in  4  byte write enables; `wen[i]` writes `wdata[8i+7:8i]`; 4'b0000 with `en`=1 is a read.
- `addr`  in  32  byte address; bits [1:0] ignored.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `led`  out  16  LED register.
- `sw`  in  16  switch inputs, sampled at read time.

## Operation
- Decode: MMIO when `addr[31:16]==MMIO_HI`, otherwise RAM. The RAM index is `addr[ADDR_W+1:2]`, so addresses outside DEPTH alias modulo DEPTH, with no error.
- MMIO offsets use `addr[15:0]`:
  - 16'hF000 LED: R/W, low 16 bits; bits 31:16 read 0.
  - 16'hF010 TIMER: R/W, 32 bits.
  - 16'hF020 SW: read-only, `{16'h0, sw}`; writes are ignored.
  - Any other offset reads 32'h0 and ignores writes.
- RAM write (`en`=1, `wen`!=0): only the enabled byte lanes update; the other lanes keep their value.
- MMIO write: the enabled lanes are merged with the current register value. LED uses lanes 0-1 only.
- Read (`en`=1): `rdata` is loaded at the edge with the addressed value as it was before that edge's write (read-first).
  - Under a write, `rdata` is also loaded with the old contents. The CPU ignores it.
- `en`=0: no access; `rdata` holds its previous value.
- TIMER:
  - On a TIMER write edge, TIMER <= merged wdata.
  - On every other edge, TIMER <= TIMER+1, wrapping 32'hFFFFFFFF -> 0.
- The CPU gates `wen` with its cancel signal. The responder does not qualify `wen` further: any `wen` bit with `en`=1 commits.
- No state machine; the only sequential state is the RAM, the registers and the `rdata` register.

## Timing
- Read latency is exactly 1 cycle: a request at edge N gives valid `rdata` after edge N, for the whole of cycle N+1.
- Back-to-back requests are accepted every cycle with no stalls and no ready signal.
- Write visibility: a write committed at edge N is returned by a read issued at edge N+1.
- TIMER read value is the pre-increment value at edge N. Two consecutive reads differ by 1.
- A TIMER write of V at edge N followed by a read at edge N+1 returns V; a read at edge N+2 returns V+1.
- Reset values (held while `resetn`=0, applied at the edge):
  - `rdata`=0, `led`=0, TIMER=0.
  - RAM contents are not reset.
  - Requests during reset are ignored: no writes, `rdata` stays 0.
- Reset deasserted at edge N: TIMER is 0 after edge N and 1 after edge N+1.
- `sw` is sampled combinationally into `rdata` at the read edge. The SoC synchronizes `sw` externally.

## Structure
- Shared package `dsram_pkg`:
  - `MMIO_HI`.
  - Offsets `LED_OFF`=16'hF000, `TIMER_OFF`=16'hF010, `SW_OFF`=16'hF020.
  - Reset constants.
- Sub-module `byte_ram`:
  - Single-port, DEPTH x 32, four byte-lane write enables, registered read-first output.
  - Written to infer block RAM.
  - The top muxes the `byte_ram` output against a registered MMIO read word, selected by a registered `is_mmio` flag.
- Top contains the decode, the LED and TIMER registers, and the read mux.

## Test plan
- RAM byte lanes: write 32'h11223344 to 0x100 with wen=4'hF, then 32'hAABBCCDD with wen=4'b0101; read 0x100 -> 32'h11BB33DD.
- Aliasing and read-first:
  - With ADDR_W=10, write 32'hCAFE0001 to 0x1000; reading 0x0000 -> 32'hCAFE0001.
  - Write 32'h5 to 0x0000 and read the same address in the same cycle -> `rdata`=32'hCAFE0001; the next read -> 32'h5.
- LED: write 32'hFFFF1234 to 0xBFAFF000, wen=4'hF -> `led`=16'h1234; read -> 32'h00001234; a write with wen=4'b1100 leaves `led`=16'h1234.
- TIMER:
  - Write 32'hFFFFFFFE to 0xBFAFF010, then read on the next 3 cycles -> 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000.
- Switch and unmapped offsets: with `sw`=16'hA5A5, read 0xBFAFF020 -> 32'h0000A5A5; a write there has no effect; read 0xBFAF0000 -> 0.
- Reset mid-operation:
  - Assert `resetn`=0 for 2 cycles while issuing a write to 0xBFAFF000 and a read of TIMER.
  - Required: `led`=0, `rdata`=0, TIMER reads 1 on the first read after reset release.
  - RAM contents written before reset are still readable.

Source files
------------

// File: rtl/dsram_pkg.sv
// Shared constants, MMIO decode and byte-lane merge for the data SRAM responder.
package dsram_pkg;

  localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;

  localparam logic [15:0] LED_OFF   = 16'hF000;
  localparam logic [15:0] TIMER_OFF = 16'hF010;
  localparam logic [15:0] SW_OFF    = 16'hF020;

  localparam logic [31:0] RST_RDATA = 32'h0;
  localparam logic [15:0] RST_LED   = 16'h0;
  localparam logic [31:0] RST_TIMER = 32'h0;

  typedef enum logic [1:0] {
    SelNone,
    SelLed,
    SelTimer,
    SelSw
  } mmio_sel_e;

  // Byte address bits [1:0] are not part of the register offset.
  function automatic mmio_sel_e decode_off(input logic [15:0] off);
    mmio_sel_e sel;
    sel = SelNone;
    if (off[15:2] == LED_OFF[15:2]) begin
      sel = SelLed;
    end else if (off[15:2] == TIMER_OFF[15:2]) begin
      sel = SelTimer;
    end else if (off[15:2] == SW_OFF[15:2]) begin
      sel = SelSw;
    end
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dsram_responder_if.sv
// CPU data-port request/response signals between the MEM stage and the responder.
interface dsram_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output en,
    output wen,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  en,
    input  wen,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/byte_ram.sv
// Single-port word RAM with byte-lane write enables and a registered read-first output.
module byte_ram #(
  parameter int unsigned AddrW = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);
  import dsram_pkg::*;

  localparam int unsigned Depth = 1 << AddrW;

  logic [31:0] mem [Depth];
  logic [31:0] rdata_q;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= RST_RDATA;
    end else if (en_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dsram_responder.sv
// Data SRAM port responder: byte-writable RAM plus LED, TIMER and switch MMIO registers.
module dsram_responder
  import dsram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  dsram_responder_if.slave   bus,
  output logic [15:0]        led,
  input  logic [15:0]        sw
);

  logic        acc;
  logic        is_mmio;
  logic        mmio_wr;
  mmio_sel_e   sel;
  logic [31:0] mmio_rd;
  logic [31:0] led_merged;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        is_mmio_q, is_mmio_d;

  logic unused_addr;
  assign unused_addr = ^bus.addr[1:0];

  always_comb begin
    acc        = bus.en & resetn;
    is_mmio    = (bus.addr[31:16] == MMIO_HI);
    sel        = decode_off(bus.addr[15:0]);
    mmio_wr    = acc & is_mmio & (|bus.wen);
    ram_en     = acc & ~is_mmio;
    ram_we     = is_mmio ? 4'b0000 : bus.wen;
    led_merged = merge_bytes({16'h0, led_q}, bus.wdata, bus.wen);

    mmio_rd = 32'h0;
    case (sel)
      SelLed:   mmio_rd = {16'h0, led_q};
      SelTimer: mmio_rd = timer_q;
      SelSw:    mmio_rd = {16'h0, sw};
      default:  mmio_rd = 32'h0;
    endcase

    // Upper lanes of the merge fall away, so LED only takes lanes 0-1.
    led_d = led_q;
    if (mmio_wr && (sel == SelLed)) begin
      led_d = led_merged[15:0];
    end

    timer_d = timer_q + 32'd1;
    if (mmio_wr && (sel == SelTimer)) begin
      timer_d = merge_bytes(timer_q, bus.wdata, bus.wen);
    end

    mmio_rdata_d = (acc && is_mmio) ? mmio_rd : mmio_rdata_q;
    is_mmio_d    = acc ? is_mmio : is_mmio_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      led_q        <= RST_LED;
      timer_q      <= RST_TIMER;
      mmio_rdata_q <= RST_RDATA;
      is_mmio_q    <= 1'b0;
    end else begin
      led_q        <= led_d;
      timer_q      <= timer_d;
      mmio_rdata_q <= mmio_rdata_d;
      is_mmio_q    <= is_mmio_d;
    end
  end

  byte_ram #(
    .AddrW(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (bus.addr[ADDR_W+1:2]),
    .wdata_i(bus.wdata),
    .rdata_o(ram_rdata)
  );

  assign bus.rdata = is_mmio_q ? mmio_rdata_q : ram_rdata;
  assign led       = led_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Randomized bench for dsram_responder against a transaction-level memory/register model.
module tb_dsram_responder;

  logic        clk;
  logic        resetn;
  logic [15:0] led;
  logic [15:0] sw;

  dsram_responder_if bus ();

  dsram_responder #(
    .ADDR_W (10),
    .MMIO_HI(16'hBFAF)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus),
    .led   (led),
    .sw    (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: RAM by word index, LED value, and TIMER as a value anchored at a cycle.
  logic [31:0] ram_m [int];
  logic [15:0] led_m;
  logic [31:0] tm_base;
  int          tm_cyc;
  int          cyc_n;
  logic [31:0] rd_m;
  logic        rd_known;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic rn);
    logic [31:0] t_now;
    logic [31:0] old_v;
    logic [31:0] mask;
    logic [13:0] o;
    logic        is_m;
    int          idx;
    resetn     = rn;
    bus.en     = e;
    bus.wen    = w;
    bus.addr   = a;
    bus.wdata  = d;
    t_now = tm_base + 32'(cyc_n - tm_cyc);
    mask  = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    is_m  = (a[31:16] == 16'hBFAF);
    o     = a[15:2];
    idx   = int'(a[11:2]);
    if (!rn) begin
      rd_m = 32'h0; rd_known = 1'b1; led_m = 16'h0;
      tm_base = 32'h0; tm_cyc = cyc_n + 1;
    end else if (e) begin
      if (is_m) begin
        case (o)
          14'h3C00: old_v = {16'h0, led_m};
          14'h3C04: old_v = t_now;
          14'h3C08: old_v = {16'h0, sw};
          default:  old_v = 32'h0;
        endcase
        rd_m = old_v; rd_known = 1'b1;
        if (w != 4'h0) begin
          if (o == 14'h3C00) led_m = 16'((old_v & ~mask) | (d & mask));
          if (o == 14'h3C04) begin
            tm_base = (t_now & ~mask) | (d & mask);
            tm_cyc  = cyc_n + 1;
          end
        end
      end else begin
        rd_known = ram_m.exists(idx);
        if (rd_known) rd_m = ram_m[idx];
        if (w != 4'h0) begin
          if (ram_m.exists(idx)) ram_m[idx] = (ram_m[idx] & ~mask) | (d & mask);
          else if (w == 4'hF) ram_m[idx] = d;
        end
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
    if (rd_known) check_eq("rdata", bus.rdata, rd_m);
    check_eq("led", {16'h0, led}, {16'h0, led_m});
  endtask

  function automatic logic [31:0] ram_addr(input int slot);
    logic [31:0] a;
    a = $urandom;
    a[11:2] = 10'((slot * 61) % 1024);
    if (a[31:16] == 16'hBFAF) a[31:16] = 16'h0;
    return a;
  endfunction

  initial begin
    logic [31:0] a;
    logic [13:0] o;
    int          op;
    cyc_n = 0; tm_base = 0; tm_cyc = 0; led_m = 0; rd_m = 0; rd_known = 1'b0;
    sw = 16'h0;
    resetn = 1'b0; bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;

    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check_eq("reset_rdata", bus.rdata, 32'h0);

    step(1'b1, 4'hF, 32'h100, 32'h11223344, 1'b1);
    step(1'b1, 4'b0101, 32'h100, 32'hAABBCCDD, 1'b1);
    step(1'b1, 4'h0, 32'h100, 32'h0, 1'b1);
    check_eq("byte_lanes", bus.rdata, 32'h11BB33DD);

    step(1'b1, 4'hF, 32'h1000, 32'hCAFE0001, 1'b1);
    step(1'b1, 4'h0, 32'h0, 32'h0, 1'b1);
    check_eq("alias", bus.rdata, 32'hCAFE0001);
    step(1'b1, 4'hF, 32'h0, 32'h5, 1'b1);
    check_eq("read_first", bus.rdata, 32'hCAFE0001);
    step(1'b1, 4'h0, 32'h0, 32'h0, 1'b1);
    check_eq("write_visible", bus.rdata, 32'h5);

    step(1'b1, 4'hF, 32'hBFAFF000, 32'hFFFF1234, 1'b1);
    check_eq("led_write", {16'h0, led}, 32'h1234);
    step(1'b1, 4'h0, 32'hBFAFF000, 32'h0, 1'b1);
    check_eq("led_read", bus.rdata, 32'h00001234);
    step(1'b1, 4'b1100, 32'hBFAFF000, 32'hFFFFFFFF, 1'b1);
    check_eq("led_hi_lanes", {16'h0, led}, 32'h1234);

    step(1'b1, 4'hF, 32'hBFAFF010, 32'hFFFFFFFE, 1'b1);
    step(1'b1, 4'h0, 32'hBFAFF010, 32'h0, 1'b1);
    check_eq("timer_0", bus.rdata, 32'hFFFFFFFE);
    step(1'b1, 4'h0, 32'hBFAFF010, 32'h0, 1'b1);
    check_eq("timer_1", bus.rdata, 32'hFFFFFFFF);
    step(1'b1, 4'h0, 32'hBFAFF010, 32'h0, 1'b1);
    check_eq("timer_wrap", bus.rdata, 32'h0);

    sw = 16'hA5A5;
    step(1'b1, 4'h0, 32'hBFAFF020, 32'h0, 1'b1);
    check_eq("sw_read", bus.rdata, 32'h0000A5A5);
    step(1'b1, 4'hF, 32'hBFAFF020, 32'h12345678, 1'b1);
    step(1'b1, 4'h0, 32'hBFAFF020, 32'h0, 1'b1);
    check_eq("sw_ro", bus.rdata, 32'h0000A5A5);
    step(1'b1, 4'h0, 32'hBFAF0000, 32'h0, 1'b1);
    check_eq("unmapped", bus.rdata, 32'h0);
    step(1'b0, 4'h0, 32'hBFAFF020, 32'h0, 1'b1);
    check_eq("idle_hold", bus.rdata, 32'h0);

    step(1'b1, 4'hF, 32'hBFAFF000, 32'hFFFFBEEF, 1'b0);
    step(1'b1, 4'h0, 32'hBFAFF010, 32'h0, 1'b0);
    check_eq("rst_led", {16'h0, led}, 32'h0);
    check_eq("rst_rdata", bus.rdata, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 4'h0, 32'hBFAFF010, 32'h0, 1'b1);
    check_eq("rst_timer", bus.rdata, 32'h1);
    step(1'b1, 4'h0, 32'h100, 32'h0, 1'b1);
    check_eq("ram_kept", bus.rdata, 32'h11BB33DD);

    for (int s = 0; s < 16; s++) step(1'b1, 4'hF, ram_addr(s), $urandom, 1'b1);

    for (int i = 0; i < 800; i++) begin
      op = $urandom_range(0, 99);
      if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
      if (op < 2) begin
        step(1'($urandom), 4'($urandom), ram_addr(0), $urandom, 1'b0);
      end else if (op < 40) begin
        step(1'b1, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
             ram_addr($urandom_range(0, 15)), $urandom, 1'b1);
      end else if (op < 85) begin
        case ($urandom_range(0, 3))
          0: o = 14'h3C00;
          1: o = 14'h3C04;
          2: o = 14'h3C08;
          default: begin
            o = 14'($urandom);
            if (o == 14'h3C00 || o == 14'h3C04 || o == 14'h3C08) o = 14'h0;
          end
        endcase
        a = {16'hBFAF, o, 2'($urandom)};
        step(1'b1, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, a, $urandom, 1'b1);
      end else begin
        step(1'b0, 4'($urandom), $urandom, $urandom, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
